// File: rtl/eio_bus_arb_pkg.sv
// Shared types and defaults for the EIO bus arbiter (eio_bus_arb and its rr_arb2 picker).
package eio_bus_arb_pkg;

  localparam int EIO_AW        = 32;
  localparam int EIO_DW        = 32;
  localparam int EIO_TO_CYCLES = 256;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUS  = 2'd1,
    ARB_RESP = 2'd2
  } EIO_ARB_STATE;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } EIO_GNT_TYPE;

  function automatic EIO_GNT_TYPE gnt_other(input EIO_GNT_TYPE g);
    return (g == GNT_I) ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/eio_bus_arb_rr_arb2.sv
// Combinational two-way round-robin pick between the fetch (I) and MEM (D) requesters.
module eio_bus_arb_rr_arb2
  import eio_bus_arb_pkg::*;
(
  input  logic        i_req_i,
  input  logic        d_req_i,
  input  EIO_GNT_TYPE last_gnt_i,
  output logic        valid_o,
  output EIO_GNT_TYPE gnt_o
);

  // Under contention the side that did not win last time goes first.
  always_comb begin
    valid_o = i_req_i | d_req_i;
    gnt_o   = GNT_I;
    if (i_req_i && d_req_i) begin
      gnt_o = gnt_other(last_gnt_i);
    end else if (d_req_i) begin
      gnt_o = GNT_D;
    end else begin
      gnt_o = GNT_I;
    end
  end

endmodule

// File: rtl/eio_bus_arb.sv
// Round-robin arbiter sharing the single EIO bus between fetch misses and MEM loads/stores.
// Optional bus watchdog compiled in with `define EIO_BUS_TIMEOUT_EN.
module eio_bus_arb
  import eio_bus_arb_pkg::*;
#(
  parameter int AW        = EIO_AW,
  parameter int DW        = EIO_DW,
  parameter int TO_CYCLES = EIO_TO_CYCLES
) (
  input  logic          clk_in,
  input  logic          reset_in,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic          i_ack_fault,
  output logic [DW-1:0] i_ack_data,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic          d_rd,
  input  logic          d_wr,
  input  logic [DW-1:0] d_wr_data,
  output logic          d_ack,
  output logic          d_ack_fault,
  output logic [DW-1:0] d_ack_data,
  output logic          eio_req,
  output logic [AW-1:0] eio_addr,
  output logic          eio_rd,
  output logic          eio_wr,
  output logic [DW-1:0] eio_wr_data,
  input  logic          eio_ack,
  input  logic          eio_ack_fault,
  input  logic [DW-1:0] eio_ack_data
);

  EIO_ARB_STATE  state_q, state_d;
  EIO_GNT_TYPE   gnt_q, gnt_d, last_gnt_q, last_gnt_d, arb_gnt_s;
  logic          arb_valid_s;
  logic          eio_req_q, eio_req_d, eio_rd_q, eio_rd_d, eio_wr_q, eio_wr_d;
  logic [AW-1:0] eio_addr_q, eio_addr_d;
  logic [DW-1:0] eio_wr_data_q, eio_wr_data_d;
  logic          i_ack_q, i_ack_d, i_fault_q, i_fault_d;
  logic          d_ack_q, d_ack_d, d_fault_q, d_fault_d;
  logic [DW-1:0] i_data_q, i_data_d, d_data_q, d_data_d;
  logic          bus_done_s, bus_fault_s, bus_to_s;
  logic [DW-1:0] bus_data_s;

  if (TO_CYCLES < 2) begin : g_to_cycles_chk
    $error("eio_bus_arb: TO_CYCLES must be at least 2");
  end

  eio_bus_arb_rr_arb2 u_rr_arb2 (
    .i_req_i    (i_req),
    .d_req_i    (d_req),
    .last_gnt_i (last_gnt_q),
    .valid_o    (arb_valid_s),
    .gnt_o      (arb_gnt_s)
  );

`ifdef EIO_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES);
  logic [CW-1:0] to_cnt_q;

  // Watchdog: cleared while idle, counts BUS cycles that pass without eio_ack.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      to_cnt_q <= {CW{1'b0}};
    end else if (state_q == ARB_IDLE) begin
      to_cnt_q <= {CW{1'b0}};
    end else if ((state_q == ARB_BUS) && !eio_ack) begin
      to_cnt_q <= to_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      to_cnt_q <= to_cnt_q;
    end
  end

  assign bus_to_s = (state_q == ARB_BUS) && (to_cnt_q == CW'(TO_CYCLES - 1));
`else
  assign bus_to_s = 1'b0;
`endif

  // Bus completion: a real ack beats a watchdog expiry in the same cycle; writes and faults return zero data.
  always_comb begin
    bus_done_s  = 1'b0;
    bus_fault_s = 1'b0;
    bus_data_s  = {DW{1'b0}};
    if ((state_q == ARB_BUS) && eio_ack) begin
      bus_done_s  = 1'b1;
      bus_fault_s = eio_ack_fault;
      bus_data_s  = (eio_rd_q && !eio_ack_fault) ? eio_ack_data : {DW{1'b0}};
    end else if (bus_to_s) begin
      bus_done_s  = 1'b1;
      bus_fault_s = 1'b1;
    end else begin
      bus_done_s  = 1'b0;
    end
  end

  // Next-state and output-register logic for the IDLE -> BUS -> RESP cycle.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_gnt_d    = last_gnt_q;
    eio_req_d     = eio_req_q;
    eio_rd_d      = eio_rd_q;
    eio_wr_d      = eio_wr_q;
    eio_addr_d    = eio_addr_q;
    eio_wr_data_d = eio_wr_data_q;
    i_ack_d       = 1'b0;
    i_fault_d     = i_fault_q;
    i_data_d      = i_data_q;
    d_ack_d       = 1'b0;
    d_fault_d     = d_fault_q;
    d_data_d      = d_data_q;
    case (state_q)
      ARB_IDLE: begin
        if (arb_valid_s) begin
          gnt_d     = arb_gnt_s;
          eio_req_d = 1'b1;
          state_d   = ARB_BUS;
          if (arb_gnt_s == GNT_I) begin
            eio_addr_d    = i_addr;
            eio_rd_d      = 1'b1;
            eio_wr_d      = 1'b0;
            eio_wr_data_d = {DW{1'b0}};
          end else begin
            eio_addr_d    = d_addr;
            eio_rd_d      = d_rd;
            eio_wr_d      = d_wr;
            eio_wr_data_d = d_wr_data;
          end
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUS: begin
        if (bus_done_s) begin
          eio_req_d = 1'b0;
          state_d   = ARB_RESP;
          if (gnt_q == GNT_I) begin
            i_ack_d   = 1'b1;
            i_fault_d = bus_fault_s;
            i_data_d  = bus_data_s;
          end else begin
            d_ack_d   = 1'b1;
            d_fault_d = bus_fault_s;
            d_data_d  = bus_data_s;
          end
        end else begin
          state_d = ARB_BUS;
        end
      end
      // The ack is visible this cycle; requests are not sampled so a stale req cannot be re-granted.
      ARB_RESP: begin
        last_gnt_d = gnt_q;
        state_d    = ARB_IDLE;
      end
      default: begin
        state_d   = ARB_IDLE;
        eio_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset leaves I winning the first tie.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q       <= ARB_IDLE;
      gnt_q         <= GNT_I;
      last_gnt_q    <= GNT_D;
      eio_req_q     <= 1'b0;
      eio_rd_q      <= 1'b0;
      eio_wr_q      <= 1'b0;
      eio_addr_q    <= {AW{1'b0}};
      eio_wr_data_q <= {DW{1'b0}};
      i_ack_q       <= 1'b0;
      i_fault_q     <= 1'b0;
      i_data_q      <= {DW{1'b0}};
      d_ack_q       <= 1'b0;
      d_fault_q     <= 1'b0;
      d_data_q      <= {DW{1'b0}};
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      last_gnt_q    <= last_gnt_d;
      eio_req_q     <= eio_req_d;
      eio_rd_q      <= eio_rd_d;
      eio_wr_q      <= eio_wr_d;
      eio_addr_q    <= eio_addr_d;
      eio_wr_data_q <= eio_wr_data_d;
      i_ack_q       <= i_ack_d;
      i_fault_q     <= i_fault_d;
      i_data_q      <= i_data_d;
      d_ack_q       <= d_ack_d;
      d_fault_q     <= d_fault_d;
      d_data_q      <= d_data_d;
    end
  end

  assign eio_req     = eio_req_q;
  assign eio_rd      = eio_rd_q;
  assign eio_wr      = eio_wr_q;
  assign eio_addr    = eio_addr_q;
  assign eio_wr_data = eio_wr_data_q;
  assign i_ack       = i_ack_q;
  assign i_ack_fault = i_fault_q;
  assign i_ack_data  = i_data_q;
  assign d_ack       = d_ack_q;
  assign d_ack_fault = d_fault_q;
  assign d_ack_data  = d_data_q;

endmodule

// File: tb/tb_eio_bus_arb.sv
// Self-checking bench for eio_bus_arb: transaction table plus hand sequences for latency, reset and timeout.
module tb_eio_bus_arb;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic        d_req = 1'b0, d_rd = 1'b0, d_wr = 1'b0;
  logic [31:0] d_addr = 32'h0, d_wr_data = 32'h0;
  logic        eio_ack = 1'b0, eio_ack_fault = 1'b0;
  logic [31:0] eio_ack_data = 32'h0;
  logic        i_ack, i_ack_fault, d_ack, d_ack_fault;
  logic [31:0] i_ack_data, d_ack_data;
  logic        eio_req, eio_rd, eio_wr;
  logic [31:0] eio_addr, eio_wr_data;

  always #5 clk_in = ~clk_in;

  eio_bus_arb #(.AW(32), .DW(32), .TO_CYCLES(16)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_ack_fault(i_ack_fault), .i_ack_data(i_ack_data),
    .d_req(d_req), .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .d_wr_data(d_wr_data),
    .d_ack(d_ack), .d_ack_fault(d_ack_fault), .d_ack_data(d_ack_data),
    .eio_req(eio_req), .eio_addr(eio_addr), .eio_rd(eio_rd), .eio_wr(eio_wr), .eio_wr_data(eio_wr_data),
    .eio_ack(eio_ack), .eio_ack_fault(eio_ack_fault), .eio_ack_data(eio_ack_data)
  );

  typedef struct {
    logic raise_i; logic [31:0] i_addr;
    logic raise_d; logic d_rd; logic d_wr; logic [31:0] d_addr; logic [31:0] d_wdata;
    int dly; logic resp_fault; logic [31:0] resp_data;
    logic exp_d; logic [31:0] exp_addr; logic exp_rd; logic exp_wr; logic [31:0] exp_wdata;
    logic exp_fault; logic [31:0] exp_data;
  } vec_t;
  typedef struct { logic [31:0] addr; logic rd; logic wr; logic [31:0] wdata; } bus_exp_t;
  typedef struct { logic side_d; logic fault; logic [31:0] data; } ack_exp_t;

  bus_exp_t bus_q[$];
  ack_exp_t ack_q[$];
  vec_t     vecs[14];
  int       n_checks = 0;
  int       n_errs = 0;
  logic     req_prev = 1'b0;
  logic [31:0] last_i, last_d;

  function automatic vec_t mk(input logic ri, input logic [31:0] ia, input logic rdq, input logic drd,
                              input logic dwr, input logic [31:0] da, input logic [31:0] dwd, input int dly,
                              input logic rf, input logic [31:0] rdat, input logic ed, input logic [31:0] ea,
                              input logic erd, input logic ewr, input logic [31:0] ewd, input logic ef,
                              input logic [31:0] edat);
    vec_t v;
    v.raise_i = ri; v.i_addr = ia; v.raise_d = rdq; v.d_rd = drd; v.d_wr = dwr; v.d_addr = da;
    v.d_wdata = dwd; v.dly = dly; v.resp_fault = rf; v.resp_data = rdat; v.exp_d = ed; v.exp_addr = ea;
    v.exp_rd = erd; v.exp_wr = ewr; v.exp_wdata = ewd; v.exp_fault = ef; v.exp_data = edat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    n_errs++;
    $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic push_bus(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] wd);
    bus_exp_t b;
    b.addr = a; b.rd = rd; b.wr = wr; b.wdata = wd;
    bus_q.push_back(b);
  endtask

  task automatic push_ack(input logic sd, input logic f, input logic [31:0] dat);
    ack_exp_t e;
    e.side_d = sd; e.fault = f; e.data = dat;
    ack_q.push_back(e);
  endtask

  // Advance to the next falling edge and score any new bus request or requester ack.
  task automatic tick();
    bus_exp_t b;
    ack_exp_t e;
    @(negedge clk_in);
    if (reset_in) begin
      if (eio_req && !req_prev) begin
        if (bus_q.size() == 0) begin
          fail("bus_unexpected", 32'(eio_req), 32'h0);
        end else begin
          b = bus_q.pop_front();
          chk("eio_addr", eio_addr, b.addr);
          chk("eio_rd", 32'(eio_rd), 32'(b.rd));
          chk("eio_wr", 32'(eio_wr), 32'(b.wr));
          chk("eio_wr_data", eio_wr_data, b.wdata);
        end
      end
      req_prev = eio_req;
      if (i_ack && d_ack) begin
        fail("ack_both", {30'h0, i_ack, d_ack}, 32'h0);
      end else if (i_ack || d_ack) begin
        if (ack_q.size() == 0) begin
          fail("ack_unexpected", {30'h0, i_ack, d_ack}, 32'h0);
        end else begin
          e = ack_q.pop_front();
          chk("ack_side_d", 32'(d_ack), 32'(e.side_d));
          chk("ack_fault", 32'(d_ack ? d_ack_fault : i_ack_fault), 32'(e.fault));
          chk("ack_data", d_ack ? d_ack_data : i_ack_data, e.data);
        end
      end else begin
        req_prev = req_prev;
      end
    end else begin
      req_prev = 1'b0;
    end
  endtask

  // Wait for the bus request, answer after dly cycles, wait for the requester ack and drop that request.
  task automatic do_txn(input int dly, input logic flt, input logic [31:0] dat);
    int n = 0;
    while (!eio_req && n < 20) begin tick(); n++; end
    if (!eio_req) begin
      fail("eio_req_timeout", 32'(eio_req), 32'h1);
    end else begin
      repeat (dly) tick();
      eio_ack = 1'b1; eio_ack_fault = flt; eio_ack_data = dat;
      tick();
      eio_ack = 1'b0; eio_ack_fault = 1'b0; eio_ack_data = 32'h5A5A_5A5A;
      n = 0;
      while (!(i_ack || d_ack) && n < 10) begin tick(); n++; end
      if (i_ack) i_req = 1'b0;
      else if (d_ack) d_req = 1'b0;
      else fail("ack_timeout", 32'h0, 32'h1);
    end
  endtask

  initial begin
    vecs[0]  = mk(1, 32'h2000, 1, 0, 1, 32'h8000_0004, 32'h1234_5678, 1, 0, 32'hA5A5_0001,
                  0, 32'h2000, 1, 0, 32'h0, 0, 32'hA5A5_0001);
    vecs[1]  = mk(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'hFFFF_FFFF,
                  1, 32'h8000_0004, 0, 1, 32'h1234_5678, 0, 32'h0);
    vecs[2]  = mk(1, 32'h1000, 0, 0, 0, 32'h0, 32'h0, 2, 0, 32'hDEAD_BEEF,
                  0, 32'h1000, 1, 0, 32'h0, 0, 32'hDEAD_BEEF);
    vecs[3]  = mk(1, 32'h3003, 1, 1, 0, 32'h9003, 32'h0, 3, 0, 32'hC0DE_0003,
                  1, 32'h9003, 1, 0, 32'h0, 0, 32'hC0DE_0003);
    vecs[4]  = mk(1, 32'h3004, 1, 1, 0, 32'h9004, 32'h0, 0, 0, 32'hC0DE_0004,
                  0, 32'h3003, 1, 0, 32'h0, 0, 32'hC0DE_0004);
    vecs[5]  = mk(1, 32'h3005, 1, 1, 0, 32'h9005, 32'h0, 1, 0, 32'hC0DE_0005,
                  1, 32'h9004, 1, 0, 32'h0, 0, 32'hC0DE_0005);
    vecs[6]  = mk(1, 32'h3006, 1, 1, 0, 32'h9006, 32'h0, 0, 0, 32'hC0DE_0006,
                  0, 32'h3005, 1, 0, 32'h0, 0, 32'hC0DE_0006);
    vecs[7]  = mk(1, 32'h3007, 1, 1, 0, 32'h9007, 32'h0, 2, 0, 32'hC0DE_0007,
                  1, 32'h9006, 1, 0, 32'h0, 0, 32'hC0DE_0007);
    vecs[8]  = mk(1, 32'h3008, 1, 1, 0, 32'h9008, 32'h0, 0, 0, 32'hC0DE_0008,
                  0, 32'h3007, 1, 0, 32'h0, 0, 32'hC0DE_0008);
    vecs[9]  = mk(1, 32'h3009, 1, 1, 0, 32'h9009, 32'h0, 1, 0, 32'hC0DE_0009,
                  1, 32'h9008, 1, 0, 32'h0, 0, 32'hC0DE_0009);
    vecs[10] = mk(1, 32'h300A, 1, 1, 0, 32'h900A, 32'h0, 0, 0, 32'hC0DE_000A,
                  0, 32'h3009, 1, 0, 32'h0, 0, 32'hC0DE_000A);
    vecs[11] = mk(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 1, 32'hBAD0_BAD0,
                  1, 32'h900A, 1, 0, 32'h0, 1, 32'h0);
    vecs[12] = mk(1, 32'h4000, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'hC0DE_000C,
                  0, 32'h4000, 1, 0, 32'h0, 0, 32'hC0DE_000C);
    vecs[13] = mk(0, 32'h0, 1, 0, 1, 32'h8000_0010, 32'h0000_0001, 2, 1, 32'h1111_1111,
                  1, 32'h8000_0010, 0, 1, 32'h0000_0001, 1, 32'h0);

    #2 reset_in = 1'b0;
    #1;
    chk("rst_eio_req", 32'(eio_req), 32'h0);
    chk("rst_eio_rd_wr", {30'h0, eio_rd, eio_wr}, 32'h0);
    chk("rst_eio_addr", eio_addr, 32'h0);
    chk("rst_acks", {28'h0, i_ack, i_ack_fault, d_ack, d_ack_fault}, 32'h0);
    chk("rst_ack_data", i_ack_data | d_ack_data, 32'h0);
    tick(); tick();
    reset_in = 1'b1;
    tick();
    chk("post_rst_idle", 32'(eio_req), 32'h0);

    for (int k = 0; k < 14; k++) begin
      if (vecs[k].raise_i && !i_req) begin i_req = 1'b1; i_addr = vecs[k].i_addr; end
      if (vecs[k].raise_d && !d_req) begin
        d_req = 1'b1; d_rd = vecs[k].d_rd; d_wr = vecs[k].d_wr;
        d_addr = vecs[k].d_addr; d_wr_data = vecs[k].d_wdata;
      end
      push_bus(vecs[k].exp_addr, vecs[k].exp_rd, vecs[k].exp_wr, vecs[k].exp_wdata);
      push_ack(vecs[k].exp_d, vecs[k].exp_fault, vecs[k].exp_data);
      do_txn(vecs[k].dly, vecs[k].resp_fault, vecs[k].resp_data);
      if (vecs[k].exp_d) last_d = vecs[k].exp_data;
      else last_i = vecs[k].exp_data;
    end
    tick();
    chk("hold_i_data", i_ack_data, last_i);
    chk("hold_d_data", d_ack_data, last_d);

    // Minimum round trip: eio_req one cycle after the request, ack one cycle after eio_ack, one-cycle pulse.
    i_req = 1'b1; i_addr = 32'h6000;
    push_bus(32'h6000, 1'b1, 1'b0, 32'h0);
    push_ack(1'b0, 1'b0, 32'h0000_0077);
    tick();
    chk("lat_eio_req", 32'(eio_req), 32'h1);
    eio_ack = 1'b1; eio_ack_data = 32'h0000_0077;
    tick();
    eio_ack = 1'b0; eio_ack_data = 32'h0;
    chk("lat_i_ack", 32'(i_ack), 32'h1);
    chk("lat_eio_req_drop", 32'(eio_req), 32'h0);
    i_req = 1'b0;
    tick();
    chk("ack_pulse_width", 32'(i_ack), 32'h0);

    eio_ack = 1'b1; eio_ack_fault = 1'b1; eio_ack_data = 32'hFFFF_0000;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("idle_ack_ignored", {29'h0, eio_req, i_ack, d_ack}, 32'h0);
    end
    eio_ack = 1'b0; eio_ack_fault = 1'b0;
    chk("idle_ack_data_held", i_ack_data, 32'h0000_0077);

`ifdef EIO_BUS_TIMEOUT_EN
    begin
      int t = 0;
      int n = 0;
      d_req = 1'b1; d_rd = 1'b1; d_wr = 1'b0; d_addr = 32'h7000; d_wr_data = 32'h0;
      push_bus(32'h7000, 1'b1, 1'b0, 32'h0);
      push_ack(1'b1, 1'b1, 32'h0);
      while (!eio_req && n < 20) begin tick(); n++; end
      while (!d_ack && t < 40) begin tick(); t++; end
      chk("to_latency", 32'(t), 32'd16);
      chk("to_eio_req_drop", 32'(eio_req), 32'h0);
      d_req = 1'b0;
      eio_ack = 1'b1; eio_ack_data = 32'h1234_0000;
      tick();
      eio_ack = 1'b0;
      tick();
      chk("to_late_ack_ignored", {29'h0, eio_req, i_ack, d_ack}, 32'h0);
    end
`endif

    i_req = 1'b1; i_addr = 32'h5000;
    push_bus(32'h5000, 1'b1, 1'b0, 32'h0);
    begin
      int n = 0;
      while (!eio_req && n < 20) begin tick(); n++; end
    end
    tick();
    #2 reset_in = 1'b0;
    #1;
    chk("midrst_eio_req", 32'(eio_req), 32'h0);
    chk("midrst_eio_addr", eio_addr, 32'h0);
    chk("midrst_data", i_ack_data | d_ack_data, 32'h0);
    tick();
    reset_in = 1'b1;
    push_bus(32'h5000, 1'b1, 1'b0, 32'h0);
    push_ack(1'b0, 1'b0, 32'hABCD_0005);
    do_txn(1, 1'b0, 32'hABCD_0005);
    tick();

    chk("bus_q_left", 32'(bus_q.size()), 32'h0);
    chk("ack_q_left", 32'(ack_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
